data_mem_ctrl: RTL and testbench

Parametrised data-memory controller for the multi-cycle RISC-V core. It replaces the fixed 64-word, word-only, zero-wait memory with the following:
- a configurable depth;
- byte, halfword and word accesses with sign or zero extension;
- a programmable wait-state count;
- a valid/ready request and response handshake, so the core's FSM can stall on memory.

It sits between the core's address/write-data path and its data register.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/data_mem_ctrl.sv | 153 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the data-memory controller.
//   SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD : req_size encodings
//   state_t : controller FSM states
//   LANE_W  : number of byte lanes in a 32-bit word
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int LANE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering.
//   addr_lo  in  2   low byte-address bits
//   size     in  2   access size (mem_pkg SZ_*)
//   is_uns   in  1   zero-extend loads when 1
//   wdata    in  32  right-aligned store data
//   rword    in  32  addressed storage word
//   wword    out 32  store data replicated onto its lanes
//   be       out 4   byte-lane write enables
//   rdata    out 32  extracted and extended load data
// Halfwords use addr_lo[1] only and words ignore addr_lo; misaligned
// requests are either rejected upstream or silently aligned here.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_uns,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rword,
  output logic [31:0]       wword,
  output logic [LANE_W-1:0] be,
  output logic [31:0]       rdata
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  assign byte_sh = rword >> {addr_lo, 3'b000};
  assign half_sh = rword >> {addr_lo[1], 4'b0000};

  always_comb begin
    be    = '0;
    wword = '0;
    rdata = '0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rdata = is_uns ? {24'b0, byte_sh[7:0]} : {{24{byte_sh[7]}}, byte_sh[7:0]};
      end
      SZ_HALF: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = is_uns ? {16'b0, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
      default: begin
        be    = '0;
        wword = '0;
        rdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable data memory with wait states and a
// valid/ready request plus one-cycle response pulse.
//   clk, reset_n               clock / async active-low reset
//   req_valid, req_ready       request handshake
//   req_we, req_addr, req_size request kind, byte address, size
//   req_unsigned, req_wdata    load extension, right-aligned store data
//   rsp_valid                  one-cycle response pulse
//   rsp_rdata, rsp_err         registered result, held until next response
// Optional macro MEM_MISALIGN_CHECK_EN: reject misaligned half/word accesses
// instead of forcing alignment.
//
// state   | meaning
// ST_IDLE | ready for a request
// ST_WAIT | counting wait states, access when cnt reaches 1
// ST_RESP | rsp_valid high for this single cycle
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 256,
  parameter int    ADDR_W      = 32,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  state_t            state;
  logic [3:0]        cnt;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [1:0]        c_size;
  logic              c_uns;
  logic [31:0]       c_wdata;

  assign req_ready = (state == ST_IDLE) && reset_n;

  logic accept;
  assign accept = req_valid && req_ready;

  // With zero latency the access uses the live request at the acceptance
  // edge; otherwise it uses the captured copy.
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [1:0]        a_size;
  logic              a_uns;
  logic [31:0]       a_wdata;
  assign a_we    = (state == ST_IDLE) ? req_we       : c_we;
  assign a_addr  = (state == ST_IDLE) ? req_addr     : c_addr;
  assign a_size  = (state == ST_IDLE) ? req_size     : c_size;
  assign a_uns   = (state == ST_IDLE) ? req_unsigned : c_uns;
  assign a_wdata = (state == ST_IDLE) ? req_wdata    : c_wdata;

  logic access;
  assign access = (accept && (LATENCY == 0)) || ((state == ST_WAIT) && (cnt == 4'd1));

  logic [ADDR_W-3:0] a_word;
  logic [IDX_W-1:0]  a_idx;
  logic              in_range;
  logic              misalign;
  logic              a_err;
  assign a_word   = a_addr[ADDR_W-1:2];
  assign a_idx    = a_word[IDX_W-1:0];
  assign in_range = ~|(a_word >> IDX_W);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = ((a_size == SZ_HALF) && a_addr[0]) ||
                    ((a_size == SZ_WORD) && (a_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign a_err = !in_range || (a_size == SZ_RSVD) || misalign;

  logic [31:0]       wword;
  logic [LANE_W-1:0] be;
  logic [31:0]       ld_data;

  mem_lane_align u_align (
    .addr_lo (a_addr[1:0]),
    .size    (a_size),
    .is_uns  (a_uns),
    .wdata   (a_wdata),
    .rword   (mem[a_idx]),
    .wword   (wword),
    .be      (be),
    .rdata   (ld_data)
  );

  // Storage has no reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (access && a_we && !a_err) begin
      for (int i = 0; i < LANE_W; i++) begin
        if (be[i]) mem[a_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      c_we      <= 1'b0;
      c_addr    <= '0;
      c_size    <= '0;
      c_uns     <= 1'b0;
      c_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (access) begin
        rsp_valid <= 1'b1;
        rsp_err   <= a_err;
        rsp_rdata <= (a_err || a_we) ? 32'd0 : ld_data;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            c_we    <= req_we;
            c_addr  <= req_addr;
            c_size  <= req_size;
            c_uns   <= req_unsigned;
            c_wdata <= req_wdata;
            cnt     <= 4'(LATENCY);
            state   <= (LATENCY == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  import mem_pkg::*;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rstn  [3];
  logic        valid [3];
  logic        rdy   [3];
  logic        rv    [3];
  logic [31:0] rd    [3];
  logic        er    [3];
  logic        we;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .LATENCY(2)) u_l2 (
    .clk(clk), .reset_n(rstn[0]), .req_valid(valid[0]), .req_ready(rdy[0]),
    .req_we(we), .req_addr(addr), .req_size(size), .req_unsigned(uns),
    .req_wdata(wdata), .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]));

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(rstn[1]), .req_valid(valid[1]), .req_ready(rdy[1]),
    .req_we(we), .req_addr(addr), .req_size(size), .req_unsigned(uns),
    .req_wdata(wdata), .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]));

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .LATENCY(0)) u_l0 (
    .clk(clk), .reset_n(rstn[2]), .req_valid(valid[2]), .req_ready(rdy[2]),
    .req_we(we), .req_addr(addr), .req_size(size), .req_unsigned(uns),
    .req_wdata(wdata), .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(er[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Issue one request to instance sel, wait for its response; lat counts
  // clock cycles from the acceptance edge to the cycle rsp_valid is high.
  task automatic do_req(input int sel, input logic w, input logic [31:0] a,
                        input logic [1:0] s, input logic u, input logic [31:0] d,
                        output int lat, output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk);
    we = w; addr = a; size = s; uns = u; wdata = d;
    valid[sel] = 1'b1;
    n = 0;
    while (!rdy[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    valid[sel] = 1'b0;
    n = 1;
    while (!rv[sel] && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = n; rdata = rd[sel]; err = er[sel];
    @(negedge clk);
    check_val("pulse_one_cycle", 32'(rv[sel]), 32'd0);
  endtask

  int          lat;
  logic [31:0] r;
  logic        e;
  int          nlow;
  int          pulses;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 1'b0; valid[i] = 1'b0;
    end
    we = 0; addr = 0; size = 0; uns = 0; wdata = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val("rst_ready", 32'(rdy[i]), 32'd0);
      check_val("rst_valid", 32'(rv[i]), 32'd0);
      check_val("rst_rdata", rd[i], 32'd0);
      check_val("rst_err", 32'(er[i]), 32'd0);
    end
    for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_val("ready_after_rst", 32'(rdy[i]), 32'd1);

    // LATENCY = 2
    do_req(0, 1, 32'h10, SZ_WORD, 0, 32'hDEADBEEF, lat, r, e);
    check_val("sw_lat", 32'(lat), 32'd3);
    check_val("sw_err", 32'(e), 32'd0);
    check_val("sw_rdata", r, 32'd0);
    do_req(0, 0, 32'h10, SZ_WORD, 0, 32'h0, lat, r, e);
    check_val("lw_lat", 32'(lat), 32'd3);
    check_val("lw_rdata", r, 32'hDEADBEEF);
    check_val("lw_err", 32'(e), 32'd0);

    do_req(0, 1, 32'h13, SZ_BYTE, 0, 32'h0000007F, lat, r, e);
    do_req(0, 0, 32'h10, SZ_WORD, 0, 32'h0, lat, r, e);
    check_val("sb_lw", r, 32'h7FADBEEF);
    do_req(0, 0, 32'h12, SZ_BYTE, 0, 32'h0, lat, r, e);
    check_val("lb", r, 32'hFFFFFFAD);
    do_req(0, 0, 32'h12, SZ_BYTE, 1, 32'h0, lat, r, e);
    check_val("lbu", r, 32'h000000AD);
    do_req(0, 0, 32'h12, SZ_HALF, 0, 32'h0, lat, r, e);
    check_val("lh", r, 32'h00007FAD);

    do_req(0, 1, 32'h14, SZ_WORD, 0, 32'h01234567, lat, r, e);
    do_req(0, 1, 32'h14, SZ_HALF, 0, 32'hFFFF8001, lat, r, e);
    do_req(0, 0, 32'h14, SZ_WORD, 0, 32'h0, lat, r, e);
    check_val("sh_lanes", r, 32'h01238001);
    do_req(0, 0, 32'h14, SZ_HALF, 0, 32'h0, lat, r, e);
    check_val("lh_neg", r, 32'hFFFF8001);
    do_req(0, 0, 32'h14, SZ_HALF, 1, 32'h0, lat, r, e);
    check_val("lhu", r, 32'h00008001);
    do_req(0, 0, 32'h16, SZ_BYTE, 1, 32'h0, lat, r, e);
    check_val("lbu_hi", r, 32'h00000023);

    // misaligned word store
    do_req(0, 1, 32'h20, SZ_WORD, 0, 32'h11111111, lat, r, e);
    do_req(0, 1, 32'h21, SZ_WORD, 0, 32'hCAFEF00D, lat, r, e);
`ifdef MEM_MISALIGN_CHECK_EN
    check_val("mis_err", 32'(e), 32'd1);
    do_req(0, 0, 32'h20, SZ_WORD, 0, 32'h0, lat, r, e);
    check_val("mis_mem", r, 32'h11111111);
`else
    check_val("mis_err", 32'(e), 32'd0);
    do_req(0, 0, 32'h20, SZ_WORD, 0, 32'h0, lat, r, e);
    check_val("mis_mem", r, 32'hCAFEF00D);
`endif

    // range and reserved size
    do_req(0, 0, DEPTH * 4, SZ_WORD, 0, 32'h0, lat, r, e);
    check_val("range_err", 32'(e), 32'd1);
    check_val("range_rdata", r, 32'd0);
    do_req(0, 1, DEPTH * 4 + 32'h10, SZ_WORD, 0, 32'h55555555, lat, r, e);
    check_val("range_st_err", 32'(e), 32'd1);
    do_req(0, 0, 32'h10, SZ_RSVD, 0, 32'h0, lat, r, e);
    check_val("rsvd_err", 32'(e), 32'd1);
    check_val("rsvd_rdata", r, 32'd0);
    do_req(0, 1, 32'h10, SZ_RSVD, 0, 32'h0, lat, r, e);
    do_req(0, 0, 32'h10, SZ_WORD, 0, 32'h0, lat, r, e);
    check_val("no_alias_write", r, 32'h7FADBEEF);
    check_val("err_cleared", 32'(e), 32'd0);

    // LATENCY = 3: reset during a pending store
    do_req(1, 1, 32'h40, SZ_WORD, 0, 32'h12345678, lat, r, e);
    check_val("l3_lat", 32'(lat), 32'd4);
    @(negedge clk);
    we = 1; addr = 32'h40; size = SZ_WORD; wdata = 32'hAAAAAAAA; valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[1] = 1'b0;
    rstn[1] = 1'b0;
    pulses = 0;
    @(negedge clk);
    check_val("rst_mid_ready", 32'(rdy[1]), 32'd0);
    @(negedge clk);
    rstn[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rv[1]) pulses++;
    end
    check_val("rst_no_rsp", 32'(pulses), 32'd0);
    do_req(1, 0, 32'h40, SZ_WORD, 0, 32'h0, lat, r, e);
    check_val("rst_store_dropped", r, 32'h12345678);

    // LATENCY = 3: request held while busy is only taken when ready
    @(negedge clk);
    we = 1; addr = 32'h44; size = SZ_WORD; wdata = 32'h0BADF00D; valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we = 0;
    nlow = 0;
    while (!rdy[1] && nlow < 20) begin
      nlow++;
      @(negedge clk);
    end
    check_val("l3_ready_low", 32'(nlow), 32'd4);
    @(posedge clk);
    @(negedge clk);
    valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    check_val("l3_held_rsp", 32'(rv[1]), 32'd1);
    check_val("l3_held_rdata", rd[1], 32'h0BADF00D);

    // LATENCY = 0: back-to-back
    @(negedge clk);
    we = 1; addr = 32'h30; size = SZ_WORD; wdata = 32'h00000055; valid[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("l0_rsp_t1", 32'(rv[2]), 32'd1);
    check_val("l0_ready_low", 32'(rdy[2]), 32'd0);
    we = 0;
    @(posedge clk);
    @(negedge clk);
    check_val("l0_ready_back", 32'(rdy[2]), 32'd1);
    check_val("l0_no_rsp", 32'(rv[2]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    valid[2] = 1'b0;
    check_val("l0_rsp2", 32'(rv[2]), 32'd1);
    check_val("l0_rdata2", rd[2], 32'h00000055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
